// File: rtl/led_iter_core.sv
`timescale 1ns/1ps
// Iterative LED-64/LED-128 block encryption core with valid/ready handshakes on both sides.
// RPC rounds are evaluated per clock by chaining copies of the single-round datapath.
module led_iter_core #(
    parameter int KEY_BITS = 64,
    parameter int RPC      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [63:0]         pt,
    input  logic [KEY_BITS-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         ct
);

    localparam int          NR   = (KEY_BITS == 128) ? 48 : 32;
    localparam logic [7:0]  KS   = 8'(KEY_BITS);
    localparam logic [63:0] SBOX = 64'hC56B_90AD_3EF8_4712;
    localparam logic [63:0] MIXM = 64'h4122_8656_BEA9_22FB;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [63:0]         s_q;
    logic [KEY_BITS-1:0] key_q;
    logic [5:0]          cnt_q;
    logic [5:0]          rc_q;

    logic [63:0] k0_in;
    logic [63:0] k0;
    logic [63:0] k1;
    logic [63:0] s_cur;
    logic [5:0]  rc_cur;
    logic [2:0]  rnum;
    logic        last_step;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX[63 - 4 * int'(x) -: 4];
    endfunction

    // GF(2^4) multiply, reduction polynomial x^4 + x + 1
    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [5:0] rc_next(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

    // One full round: AddConstants, SubCells, ShiftRows, MixColumnsSerial
    function automatic logic [63:0] led_round(input logic [63:0] s, input logic [5:0] rc);
        logic [3:0]  c [16];
        logic [3:0]  t [16];
        logic [3:0]  acc;
        logic [63:0] r;
        for (int n = 0; n < 16; n++) c[n] = s[63 - 4 * n -: 4];
        c[0]  = c[0]  ^ KS[7:4];
        c[4]  = c[4]  ^ (KS[7:4] ^ 4'd1);
        c[8]  = c[8]  ^ (KS[3:0] ^ 4'd2);
        c[12] = c[12] ^ (KS[3:0] ^ 4'd3);
        c[1]  = c[1]  ^ {1'b0, rc[5:3]};
        c[5]  = c[5]  ^ {1'b0, rc[2:0]};
        c[9]  = c[9]  ^ {1'b0, rc[5:3]};
        c[13] = c[13] ^ {1'b0, rc[2:0]};
        for (int n = 0; n < 16; n++) c[n] = sbox(c[n]);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                t[4 * i + j] = c[4 * i + ((j + i) % 4)];
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int col = 0; col < 4; col++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(MIXM[63 - 4 * (4 * i + j) -: 4], t[4 * j + col]);
                r[63 - 4 * (4 * i + col) -: 4] = acc;
            end
        end
        return r;
    endfunction

    generate
        if (KEY_BITS == 128) begin : g_key128
            assign k0_in = key[127:64];
            assign k0    = key_q[127:64];
            assign k1    = key_q[63:0];
        end else begin : g_key64
            assign k0_in = key[63:0];
            assign k0    = key_q[63:0];
            assign k1    = key_q[63:0];
        end
    endgenerate

    // Unrolled round chain; a step key follows every fourth round, odd steps take K1
    always_comb begin
        s_cur  = s_q;
        rc_cur = rc_q;
        rnum   = '0;
        for (int k = 0; k < RPC; k++) begin
            rnum   = cnt_q[2:0] + 3'(k) + 3'd1;
            rc_cur = rc_next(rc_cur);
            s_cur  = led_round(s_cur, rc_cur)
                   ^ ((rnum[1:0] == 2'b00) ? (rnum[2] ? k1 : k0) : 64'h0);
        end
    end

    assign last_step = (7'(cnt_q) + 7'(RPC)) == 7'(NR);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_step) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ct is only written at the end of a block, so it stays stable under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= '0;
            key_q <= '0;
            cnt_q <= '0;
            rc_q  <= '0;
            ct    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        s_q   <= pt ^ k0_in;
                        key_q <= key;
                        cnt_q <= '0;
                        rc_q  <= '0;
                    end
                end
                RUN: begin
                    s_q  <= s_cur;
                    rc_q <= rc_cur;
                    if (last_step) ct <= s_cur;
                    else           cnt_q <= cnt_q + 6'(RPC);
                end
                default: ;
            endcase
        end
    end

endmodule
